imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of the instruction fetch path: fills the 64 KB instruction memory (16384 x 32-bit words, word address = PC[15:2]) from a byte stream, such as a UART receiver.
- Assembles little-endian 32-bit words, writes them to consecutive word addresses starting at 0, and holds the CPU core in reset while loading.
- Sits between the byte-source block and the write port of the instruction RAM; the fetch stage keeps the read port.

Parameters:
ADDR_W, 14, word-address width of instruction memory (16384 words)
TIMEOUT, 1000000, max idle cycles between bytes while receiving before error
BOOT_HOLD, 1, 1: cpu_rst_n low from reset until first successful load; 0: cpu_rst_n high while IDLE

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a load of len words
len  in  ADDR_W+1  number of words to load (0..16384), sampled on accepted start
rx_valid  in  1  byte-stream valid
rx_data  in  8  byte-stream data
rx_ready  out  1  byte accepted when rx_valid & rx_ready on a rising edge
imem_we  out  1  instruction RAM write enable, one cycle per word
imem_wa  out  ADDR_W  instruction RAM word address
imem_wd  out  32  instruction RAM write data
busy  out  1  high in RECV/WRITE
done  out  1  high in DONE
err  out  1  high in ERR
cpu_rst_n  out  1  active-low reset to the core

Behaviour:
- Reset: state IDLE, byte_idx=0, word_addr=0, shift reg=0, timer=0. Outputs rx_ready=0, imem_we=0, imem_wa=0, imem_wd=0, busy=0, done=0, err=0, cpu_rst_n=~BOOT_HOLD.
- Asynchronous reset mid-load aborts immediately. Memory contents already written are left as-is.
- States: IDLE, RECV, WRITE, DONE, ERR.
- IDLE: on start, latch len. If len==0, go to DONE; otherwise go to RECV and clear word_addr, byte_idx and timer.
- IDLE, any other start: start in RECV or WRITE is ignored. start in DONE or ERR acts as in IDLE.
- RECV: rx_ready=1 and cpu_rst_n=0.
  - On each accepted byte: shift reg byte lane[byte_idx] <= rx_data (byte0 -> bits 7:0, byte3 -> bits 31:24); byte_idx++; timer clears.
  - When the 4th byte is accepted (byte_idx==3), go to WRITE.
  - With no accepted byte, timer++. When timer reaches TIMEOUT-1, go to ERR.
- WRITE: exactly one cycle. imem_we=1, imem_wa=word_addr, imem_wd=assembled word, rx_ready=0 (one bubble per word).
  - Next cycle: if word_addr==len-1, go to DONE; otherwise word_addr++, byte_idx=0, go to RECV.
- imem_wa and imem_wd are registered outputs that hold their last values outside WRITE. imem_we is high only in WRITE.
- Latency: last byte of a word accepted at edge N -> imem_we high in cycle N+1 -> RECV (or DONE) at edge N+2.
- DONE: done=1, cpu_rst_n=1, rx_ready=0. Stays until start.
- ERR: err=1, cpu_rst_n=0, rx_ready=0. A partial word is never written. Stays until start.
- Address wrap: len>16384 is clamped to 16384. word_addr never wraps past 16383.
- Bytes offered while rx_ready=0 are not consumed; the source must hold them.
- start in the same cycle as rx_valid in IDLE: start is taken and the byte is not accepted (rx_ready is still 0 that cycle).

Decomposition:
- Shared package: state encoding enum (IDLE, RECV, WRITE, DONE, ERR), IMEM_ADDR_W=14, IMEM_WORDS=16384.
- The PC[15:2] addressing convention is the same constant used by the fetch stage.
- One natural sub-module: word_assembler (byte_idx counter plus 32-bit little-endian shift/lane register, with a word_full flag). FSM and timer stay in imem_loader.

Test Plan:
- Reset with BOOT_HOLD=1 -> all outputs 0 except nothing high; cpu_rst_n=0 and stays 0 with no start.
- start, len=2, bytes 13 00 00 00 B7 02 01 00 back-to-back -> imem_we pulses twice:
  - wa=0, wd=32'h00000013
  - wa=1, wd=32'h000102B7
  - rx_ready low exactly 1 cycle after each 4th byte; done=1 and cpu_rst_n=1 two cycles after the last byte.
- start, len=0 -> DONE the next cycle; no imem_we; cpu_rst_n=1.
- start, len=1, send 2 bytes then idle with TIMEOUT=16 -> err=1 after 16 idle cycles; no imem_we; cpu_rst_n=0. A new start with len=1 plus 4 bytes EF BE AD DE -> wa=0, wd=32'hDEADBEEF, done=1.
- rx_valid toggled randomly, len=4, start pulsed again mid-load -> second start ignored; 4 words written to wa 0..3 in order with correct data.
- rst_n asserted after 6 of 8 bytes -> outputs return to reset values asynchronously; exactly one write has occurred (wa=0).

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory write path: word addressing
// (PC[15:2]) and loader state encodings.
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 14;
    localparam int IMEM_WORDS  = 16384;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RECV  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler: byte lane counter plus lane register.
// word_next is the word as it will look once the current byte is loaded.
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [1:0]  byte_idx;
    logic [31:0] lanes;

    always_comb begin
        word_next = lanes;
        case (byte_idx)
            2'd0:    word_next[7:0]   = byte_in;
            2'd1:    word_next[15:8]  = byte_in;
            2'd2:    word_next[23:16] = byte_in;
            default: word_next[31:24] = byte_in;
        endcase
    end

    // Set while the pending byte is the last lane of the word.
    assign word_full = (byte_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= '0;
            lanes    <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (load) begin
            byte_idx <= byte_idx + 2'd1;
            lanes    <= word_next;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction RAM from a byte stream, holding the core in reset
// while loading.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int TIMEOUT   = 1000000,
    parameter int BOOT_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_wa,
    output logic [31:0]       imem_wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_n
);

    localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TLIM     = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic            IDLE_RUN = (BOOT_HOLD == 0);

    logic [2:0]        state;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [TW-1:0]     timer;
    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W-1:0] len_m1;
    logic              accept;
    logic              take_start;
    logic              asm_clear;
    logic [31:0]       word_next;
    logic              word_full;

    assign len_eff    = (len > MAX_LEN) ? MAX_LEN : len;
    assign len_m1     = ADDR_W'(len_eff - 1'b1);
    assign take_start = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign accept     = rx_valid && (state == ST_RECV);
    assign asm_clear  = take_start || (state == ST_WRITE);

    imem_loader_word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (asm_clear),
        .load      (accept),
        .byte_in   (rx_data),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            word_addr <= '0;
            last_addr <= '0;
            timer     <= '0;
            imem_wa   <= '0;
            imem_wd   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (take_start) begin
                        if (len == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_RECV;
                            word_addr <= '0;
                            timer     <= '0;
                            last_addr <= len_m1;
                        end
                    end
                end
                ST_RECV: begin
                    if (accept) begin
                        timer <= '0;
                        // Address/data captured here so they hold after WRITE.
                        if (word_full) begin
                            state   <= ST_WRITE;
                            imem_wa <= word_addr;
                            imem_wd <= word_next;
                        end
                    end else if (timer == TLIM) begin
                        state <= ST_ERR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (word_addr == last_addr) begin
                        state <= ST_DONE;
                    end else begin
                        word_addr <= word_addr + 1'b1;
                        state     <= ST_RECV;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rx_ready = (state == ST_RECV);
    assign imem_we  = (state == ST_WRITE);
    assign busy     = (state == ST_RECV) || (state == ST_WRITE);
    assign done     = (state == ST_DONE);
    assign err      = (state == ST_ERR);

    always_comb begin
        case (state)
            ST_DONE: cpu_rst_n = 1'b1;
            ST_IDLE: cpu_rst_n = IDLE_RUN;
            default: cpu_rst_n = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized byte streams
// compared against a word-level model of the expected RAM writes.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [14:0] len = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready, imem_we, busy, done, err, cpu_rst_n;
    logic [13:0] imem_wa;
    logic [31:0] imem_wd;

    int checks = 0;
    int fails  = 0;

    logic [13:0] got_wa[$];
    logic [31:0] got_wd[$];

    imem_loader #(.ADDR_W(14), .TIMEOUT(16), .BOOT_HOLD(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .imem_wa   (imem_wa),
        .imem_wd   (imem_wd),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_rst_n (cpu_rst_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            got_wa.push_back(imem_wa);
            got_wd.push_back(imem_wd);
        end
    end

    function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
        return 32'(b0) + 32'(b1) * 32'd256 + 32'(b2) * 32'd65536 + 32'(b3) * 32'd16777216;
    endfunction

    task automatic clear_log();
        got_wa.delete();
        got_wd.delete();
    endtask

    task automatic pulse_start(input logic [14:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents a byte until it is accepted; leaves rx_valid high on return.
    task automatic send_byte(input logic [7:0] b, input int gap, output int waits);
        logic acc;
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        waits = 0;
        acc = 1'b0;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk); #1;
            waits++;
        end
        checks++;
        if (!acc) begin
            fails++;
            $display("FAIL byte_accept: byte %h not accepted after %0d cycles, required acceptance", b, waits);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_ready, imem_we, busy, done, err, cpu_rst_n} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b required 000000", {rx_ready, imem_we, busy, done, err, cpu_rst_n});
        end
        checks++;
        if (imem_wa !== 14'd0 || imem_wd !== 32'd0) begin
            fails++;
            $display("FAIL reset_wa_wd: got wa=%h wd=%h required 0/0", imem_wa, imem_wd);
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (cpu_rst_n !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL boot_hold: got cpu_rst_n=%b done=%b busy=%b required 0/0/0", cpu_rst_n, done, busy);
        end
    endtask

    task automatic test_len_zero();
        clear_log();
        pulse_start(15'd0);
        checks++;
        if (done !== 1'b1 || cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL len_zero: got done=%b cpu_rst_n=%b busy=%b required 1/1/0", done, cpu_rst_n, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got_wa.size() != 0) begin
            fails++;
            $display("FAIL len_zero_writes: got %0d writes required 0", got_wa.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  b[8];
        logic [31:0] exp_wd[2];
        int w;
        b[0] = 8'h13; b[1] = 8'h00; b[2] = 8'h00; b[3] = 8'h00;
        b[4] = 8'hB7; b[5] = 8'h02; b[6] = 8'h01; b[7] = 8'h00;
        exp_wd[0] = pack(b[0], b[1], b[2], b[3]);
        exp_wd[1] = pack(b[4], b[5], b[6], b[7]);
        clear_log();
        pulse_start(15'd2);
        for (int i = 0; i < 8; i++) begin
            send_byte(b[i], 0, w);
            if (i == 3 || i == 7) begin
                checks++;
                if (imem_we !== 1'b1 || rx_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_write_cycle: byte %0d got we=%b rx_ready=%b required 1/0", i, imem_we, rx_ready);
                end
            end
            if (i == 4) begin
                checks++;
                if (w != 2) begin
                    fails++;
                    $display("FAIL b2b_bubble: got %0d cycles for byte 4 required 2", w);
                end
            end
            if (i == 7) begin
                checks++;
                if (done !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_done_early: got done=%b required 0", done);
                end
            end
        end
        rx_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done: got done=%b cpu_rst_n=%b busy=%b required 1/1/0", done, cpu_rst_n, busy);
        end
        checks++;
        if (got_wa.size() != 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d writes required 2", got_wa.size());
        end else begin
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (got_wa[j] !== 14'(j) || got_wd[j] !== exp_wd[j]) begin
                    fails++;
                    $display("FAIL b2b_word%0d: got wa=%h wd=%h required wa=%h wd=%h", j, got_wa[j], got_wd[j], 14'(j), exp_wd[j]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int w, n;
        clear_log();
        pulse_start(15'd1);
        send_byte(8'h11, 0, w);
        send_byte(8'h22, 0, w);
        rx_valid = 1'b0;
        n = 0;
        while (!err && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 16) begin
            fails++;
            $display("FAIL timeout_cycles: got err after %0d idle cycles required 16", n);
        end
        checks++;
        if (cpu_rst_n !== 1'b0 || got_wa.size() != 0 || rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL timeout_state: got cpu_rst_n=%b writes=%0d rx_ready=%b required 0/0/0", cpu_rst_n, got_wa.size(), rx_ready);
        end
        // Restart with a byte already offered in the start cycle.
        start    = 1'b1;
        len      = 15'd1;
        rx_valid = 1'b1;
        rx_data  = 8'hEF;
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL start_with_byte: got rx_ready=%b required 0", rx_ready);
        end
        @(posedge clk); #1;
        start = 1'b0;
        send_byte(8'hEF, 0, w);
        send_byte(8'hBE, 0, w);
        send_byte(8'hAD, 0, w);
        send_byte(8'hDE, 0, w);
        rx_valid = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL recover_done: got done=%b err=%b required 1/0", done, err);
        end
        checks++;
        if (got_wa.size() != 1 || got_wa[0] !== 14'd0 || got_wd[0] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL recover_word: got %0d writes wa=%h wd=%h required 1 write wa=0 wd=deadbeef",
                     got_wa.size(), got_wa.size() > 0 ? got_wa[0] : 14'h0, got_wd.size() > 0 ? got_wd[0] : 32'h0);
        end
    endtask

    task automatic test_random_restart();
        logic [7:0] b[16];
        int n, w, t;
        for (int it = 0; it < 3; it++) begin
            n = (it == 0) ? 4 : int'($urandom_range(1, 4));
            for (int k = 0; k < 16; k++) b[k] = 8'($urandom);
            clear_log();
            pulse_start(15'(n));
            for (int k = 0; k < 4 * n; k++) begin
                if (k == 6) begin
                    rx_valid = 1'b0;
                    start = 1'b1;
                    len   = 15'($urandom_range(0, 3));
                    @(posedge clk); #1;
                    start = 1'b0;
                end
                send_byte(b[k], int'($urandom_range(0, 2)), w);
            end
            rx_valid = 1'b0;
            t = 0;
            while (!done && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            checks++;
            if (done !== 1'b1) begin
                fails++;
                $display("FAIL rand%0d_done: got done=%b required 1", it, done);
            end
            checks++;
            if (got_wa.size() != n) begin
                fails++;
                $display("FAIL rand%0d_count: got %0d writes required %0d", it, got_wa.size(), n);
            end else begin
                for (int j = 0; j < n; j++) begin
                    checks++;
                    if (got_wa[j] !== 14'(j) ||
                        got_wd[j] !== pack(b[4*j], b[4*j+1], b[4*j+2], b[4*j+3])) begin
                        fails++;
                        $display("FAIL rand%0d_word%0d: got wa=%h wd=%h required wa=%h wd=%h", it, j,
                                 got_wa[j], got_wd[j], 14'(j), pack(b[4*j], b[4*j+1], b[4*j+2], b[4*j+3]));
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] b[6];
        int w;
        for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
        clear_log();
        pulse_start(15'd2);
        for (int k = 0; k < 6; k++) send_byte(b[k], 0, w);
        rx_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_ready, imem_we, busy, done, err, cpu_rst_n} !== 6'b0) begin
            fails++;
            $display("FAIL async_flags: got %b required 000000", {rx_ready, imem_we, busy, done, err, cpu_rst_n});
        end
        checks++;
        if (imem_wa !== 14'd0 || imem_wd !== 32'd0) begin
            fails++;
            $display("FAIL async_wa_wd: got wa=%h wd=%h required 0/0", imem_wa, imem_wd);
        end
        checks++;
        if (got_wa.size() != 1 || got_wa[0] !== 14'd0 || got_wd[0] !== pack(b[0], b[1], b[2], b[3])) begin
            fails++;
            $display("FAIL async_writes: got %0d writes required 1 at wa=0 wd=%h", got_wa.size(), pack(b[0], b[1], b[2], b[3]));
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_len_zero();
        test_back_to_back();
        test_timeout();
        test_random_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
